// File: rtl/rf_scoreboard.sv
// Architectural register file with write-to-read bypass, a per-register busy
// scoreboard for outstanding write-backs, a registered debug port and a saturating write counter.
module rf_scoreboard #(
  parameter int DW   = 32,
  parameter int NREG = 32,
  parameter int CW   = 16,
  localparam int AW  = $clog2(NREG)
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          RFWr,
  input  logic [AW-1:0] A3,
  input  logic [DW-1:0] WD,
  input  logic [AW-1:0] A1,
  input  logic [AW-1:0] A2,
  output logic [DW-1:0] RD1,
  output logic [DW-1:0] RD2,
  input  logic          rsv_en,
  input  logic [AW-1:0] rsv_addr,
  output logic          busy1,
  output logic          busy2,
  input  logic [AW-1:0] dbg_addr,
  output logic [DW-1:0] dbg_data,
  output logic [CW-1:0] wr_cnt
);

  logic [DW-1:0]   regs [NREG];
  logic [NREG-1:0] busy;
  logic [NREG-1:0] busy_next;
  logic            commit;
  logic            reserve;
  logic            hit1;
  logic            hit2;

  assign commit  = RFWr && (A3 != '0);
  assign reserve = rsv_en && (rsv_addr != '0);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else if (commit) begin
      regs[A3] <= WD;
    end
  end

  // A reservation on the same edge as a write-back belongs to a younger
  // instruction, so the set is applied after the clear.
  always_comb begin
    busy_next = busy;
    if (commit)  busy_next[A3]       = 1'b0;
    if (reserve) busy_next[rsv_addr] = 1'b1;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) busy <= '0;
    else       busy <= busy_next;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      dbg_data <= '0;
    end else begin
      dbg_data <= (dbg_addr == '0) ? '0 : regs[dbg_addr];
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_cnt <= '0;
    end else if (commit && (wr_cnt != '1)) begin
      wr_cnt <= wr_cnt + 1'b1;
    end
  end

  // A nonzero read index matching A3 implies a committing write, so the
  // bypass also cancels the hazard in the write-back cycle.
  assign hit1 = RFWr && (A3 == A1);
  assign hit2 = RFWr && (A3 == A2);

  assign RD1   = (A1 == '0) ? '0 : (hit1 ? WD : regs[A1]);
  assign RD2   = (A2 == '0) ? '0 : (hit2 ? WD : regs[A2]);
  assign busy1 = busy[A1] && !hit1;
  assign busy2 = busy[A2] && !hit2;

endmodule

// File: tb/tb_rf_scoreboard.sv
// Directed, table-driven bench for rf_scoreboard, built with a 4-bit write
// counter so saturation is reachable in a few cycles.
module tb_rf_scoreboard;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rstn;
  logic          RFWr;
  logic [AW-1:0] A3;
  logic [DW-1:0] WD;
  logic [AW-1:0] A1;
  logic [AW-1:0] A2;
  logic [DW-1:0] RD1;
  logic [DW-1:0] RD2;
  logic          rsv_en;
  logic [AW-1:0] rsv_addr;
  logic          busy1;
  logic          busy2;
  logic [AW-1:0] dbg_addr;
  logic [DW-1:0] dbg_data;
  logic [CW-1:0] wr_cnt;

  int checks = 0;
  int errors = 0;

  rf_scoreboard #(.DW(DW), .NREG(32), .CW(CW)) dut (
    .clk(clk), .rstn(rstn), .RFWr(RFWr), .A3(A3), .WD(WD), .A1(A1), .A2(A2),
    .RD1(RD1), .RD2(RD2), .rsv_en(rsv_en), .rsv_addr(rsv_addr),
    .busy1(busy1), .busy2(busy2), .dbg_addr(dbg_addr), .dbg_data(dbg_data),
    .wr_cnt(wr_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          rfwr;
    logic [AW-1:0] a3;
    logic [DW-1:0] wd;
    logic [AW-1:0] a1;
    logic [AW-1:0] a2;
    logic          rsv;
    logic [AW-1:0] raddr;
    logic [DW-1:0] exp_rd1;
    logic [DW-1:0] exp_rd2;
    logic          exp_b1;
    logic          exp_b2;
    int            exp_cnt;
  } vec_t;

  vec_t vecs[18];

  task automatic checkOutput(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Inputs change on the falling edge; outputs are sampled 2 ns later.
  task automatic applyStimulus(input logic rfwr, input logic [AW-1:0] a3, input logic [DW-1:0] wd,
                               input logic [AW-1:0] a1, input logic [AW-1:0] a2,
                               input logic rsv, input logic [AW-1:0] raddr);
    @(negedge clk);
    RFWr = rfwr; A3 = a3; WD = wd; A1 = a1; A2 = a2; rsv_en = rsv; rsv_addr = raddr;
    #2;
  endtask

  task automatic setVec(input int idx, input logic rfwr, input logic [AW-1:0] a3, input logic [DW-1:0] wd,
                        input logic [AW-1:0] a1, input logic [AW-1:0] a2, input logic rsv,
                        input logic [AW-1:0] raddr, input logic [DW-1:0] e1, input logic [DW-1:0] e2,
                        input logic b1, input logic b2, input int cnt);
    vecs[idx] = '{rfwr, a3, wd, a1, a2, rsv, raddr, e1, e2, b1, b2, cnt};
  endtask

  initial begin
    int exp_cnt;

    rstn = 1'b0; RFWr = 1'b0; A3 = '0; WD = '0; A1 = 5'd5; A2 = 5'd7;
    rsv_en = 1'b0; rsv_addr = '0; dbg_addr = '0;

    setVec(0,  1, 7,  32'hDEAD_BEEF, 7,  0,  0, 0,  32'hDEAD_BEEF, 32'h0,         0, 0, 0);
    setVec(1,  0, 0,  32'h0,         7,  7,  0, 0,  32'hDEAD_BEEF, 32'hDEAD_BEEF, 0, 0, 1);
    setVec(2,  1, 0,  32'hFFFF_FFFF, 0,  7,  1, 0,  32'h0,         32'hDEAD_BEEF, 0, 0, 1);
    setVec(3,  0, 0,  32'h0,         0,  0,  0, 0,  32'h0,         32'h0,         0, 0, 1);
    setVec(4,  0, 0,  32'h0,         3,  3,  1, 3,  32'h0,         32'h0,         0, 0, 1);
    setVec(5,  0, 0,  32'h0,         3,  7,  0, 0,  32'h0,         32'hDEAD_BEEF, 1, 0, 1);
    setVec(6,  0, 0,  32'h0,         3,  7,  0, 0,  32'h0,         32'hDEAD_BEEF, 1, 0, 1);
    setVec(7,  0, 0,  32'h0,         3,  7,  0, 0,  32'h0,         32'hDEAD_BEEF, 1, 0, 1);
    setVec(8,  0, 0,  32'h0,         3,  7,  0, 0,  32'h0,         32'hDEAD_BEEF, 1, 0, 1);
    setVec(9,  1, 3,  32'h55,        3,  3,  0, 0,  32'h55,        32'h55,        0, 0, 1);
    setVec(10, 0, 0,  32'h0,         3,  7,  0, 0,  32'h55,        32'hDEAD_BEEF, 0, 0, 2);
    setVec(11, 0, 0,  32'h0,         4,  0,  1, 4,  32'h0,         32'h0,         0, 0, 2);
    setVec(12, 1, 4,  32'h44,        4,  4,  1, 4,  32'h44,        32'h44,        0, 0, 2);
    setVec(13, 0, 0,  32'h0,         4,  4,  0, 0,  32'h44,        32'h44,        1, 1, 3);
    setVec(14, 1, 9,  32'h99,        9,  10, 1, 10, 32'h99,        32'h0,         0, 0, 3);
    setVec(15, 0, 0,  32'h0,         9,  10, 0, 0,  32'h99,        32'h0,         0, 1, 4);
    setVec(16, 1, 10, 32'hA0,        10, 4,  0, 0,  32'hA0,        32'h44,        0, 1, 4);
    setVec(17, 0, 0,  32'h0,         10, 4,  0, 0,  32'hA0,        32'h44,        0, 1, 5);

    // Reset state
    repeat (2) @(posedge clk);
    #2;
    checkOutput("reset_rd1", RD1, 32'h0);
    checkOutput("reset_rd2", RD2, 32'h0);
    checkOutput("reset_busy", {30'h0, busy1, busy2}, 32'h0);
    checkOutput("reset_dbg", dbg_data, 32'h0);
    checkOutput("reset_cnt", {28'h0, wr_cnt}, 32'h0);
    @(negedge clk);
    rstn = 1'b1;

    // Asynchronous reset between edges clears a committed register at once
    applyStimulus(1, 5, 32'h1234_5678, 5, 0, 0, 0);
    applyStimulus(0, 0, 32'h0, 5, 0, 0, 0);
    checkOutput("pre_async_rd1", RD1, 32'h1234_5678);
    rstn = 1'b0;
    #1;
    checkOutput("async_rst_rd1", RD1, 32'h0);
    checkOutput("async_rst_cnt", {28'h0, wr_cnt}, 32'h0);
    @(negedge clk);
    rstn = 1'b1;

    for (int i = 0; i < 18; i++) begin
      applyStimulus(vecs[i].rfwr, vecs[i].a3, vecs[i].wd, vecs[i].a1, vecs[i].a2, vecs[i].rsv, vecs[i].raddr);
      checkOutput($sformatf("v%0d_rd1", i), RD1, vecs[i].exp_rd1);
      checkOutput($sformatf("v%0d_rd2", i), RD2, vecs[i].exp_rd2);
      checkOutput($sformatf("v%0d_busy1", i), {31'h0, busy1}, {31'h0, vecs[i].exp_b1});
      checkOutput($sformatf("v%0d_busy2", i), {31'h0, busy2}, {31'h0, vecs[i].exp_b2});
      checkOutput($sformatf("v%0d_cnt", i), {28'h0, wr_cnt}, vecs[i].exp_cnt);
    end

    // Debug port shows pre-edge contents one cycle later
    dbg_addr = 5'd7;
    applyStimulus(1, 7, 32'h77, 0, 0, 0, 0);
    applyStimulus(0, 0, 32'h0, 7, 0, 0, 0);
    checkOutput("dbg_pre_edge", dbg_data, 32'hDEAD_BEEF);
    checkOutput("rd1_after_dbgwr", RD1, 32'h77);
    applyStimulus(0, 0, 32'h0, 0, 0, 0, 0);
    checkOutput("dbg_new", dbg_data, 32'h77);
    dbg_addr = 5'd0;
    applyStimulus(0, 0, 32'h0, 0, 0, 0, 0);
    checkOutput("dbg_x0", dbg_data, 32'h0);

    // Counter saturation
    exp_cnt = 6;
    for (int i = 0; i < 20; i++) begin
      applyStimulus(1, 12, i + 1, 0, 0, 0, 0);
      checkOutput($sformatf("sat_cnt%0d", i), {28'h0, wr_cnt}, exp_cnt);
      exp_cnt = (exp_cnt < 15) ? exp_cnt + 1 : 15;
    end
    applyStimulus(0, 0, 32'h0, 12, 0, 0, 0);
    checkOutput("sat_final", {28'h0, wr_cnt}, 32'd15);
    checkOutput("sat_rd1", RD1, 32'd20);

    // Writes and reservations are ignored while reset is held
    dbg_addr = 5'd12;
    applyStimulus(0, 0, 32'h0, 12, 0, 0, 0);
    checkOutput("dbg_before_rst", dbg_data, 32'd20);
    rstn = 1'b0;
    #1;
    checkOutput("rst2_rd1", RD1, 32'h0);
    checkOutput("rst2_cnt", {28'h0, wr_cnt}, 32'h0);
    checkOutput("rst2_dbg", dbg_data, 32'h0);
    applyStimulus(1, 12, 32'hABC, 13, 0, 1, 12);
    applyStimulus(1, 12, 32'hABC, 13, 0, 1, 12);
    applyStimulus(0, 0, 32'h0, 12, 0, 0, 0);
    checkOutput("rst2_hold_rd1", RD1, 32'h0);
    checkOutput("rst2_hold_busy", {31'h0, busy1}, 32'h0);
    checkOutput("rst2_hold_cnt", {28'h0, wr_cnt}, 32'h0);
    checkOutput("rst2_hold_dbg", dbg_data, 32'h0);

    // First edge after release commits normally
    @(negedge clk);
    rstn = 1'b1;
    RFWr = 1'b1; A3 = 5'd12; WD = 32'h1;
    applyStimulus(0, 0, 32'h0, 12, 0, 0, 0);
    checkOutput("post_rst_rd1", RD1, 32'h1);
    checkOutput("post_rst_cnt", {28'h0, wr_cnt}, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
